reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 71 +++++++
 tb/tb_reg_file_mp.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Two-read / two-write register file with registered read data and read-valid strobes.
// Define REG_FILE_MP_BYPASS_EN for write-first forwarding; the default build is read-first.
module reg_file_mp #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int ZERO_R0 = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  input  logic          RE1,
  input  logic          RE2,
  output logic [DW-1:0] RD1,
  output logic [DW-1:0] RD2,
  output logic          RV1,
  output logic          RV2,
  input  logic [AW-1:0] A3,
  input  logic [DW-1:0] WD3,
  input  logic          WE3,
  input  logic [AW-1:0] A4,
  input  logic [DW-1:0] WD4,
  input  logic          WE4
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata1, rdata2;
  logic          wr3_ok, wr4_ok;

  assign wr3_ok = WE3 && !((ZERO_R0 != 0) && (A3 == '0));
  assign wr4_ok = WE4 && !((ZERO_R0 != 0) && (A4 == '0));

  // Port B is applied after port A so it wins on both the bypass path and the array write.
  always_comb begin
    rdata1 = mem[A1];
`ifdef REG_FILE_MP_BYPASS_EN
    if (WE3 && (A3 == A1)) rdata1 = WD3;
    if (WE4 && (A4 == A1)) rdata1 = WD4;
`endif
    if ((ZERO_R0 != 0) && (A1 == '0)) rdata1 = '0;
  end

  always_comb begin
    rdata2 = mem[A2];
`ifdef REG_FILE_MP_BYPASS_EN
    if (WE3 && (A3 == A2)) rdata2 = WD3;
    if (WE4 && (A4 == A2)) rdata2 = WD4;
`endif
    if ((ZERO_R0 != 0) && (A2 == '0)) rdata2 = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: '0};
      RD1 <= '0;
      RD2 <= '0;
      RV1 <= 1'b0;
      RV2 <= 1'b0;
    end else begin
      if (wr3_ok) mem[A3] <= WD3;
      if (wr4_ok) mem[A4] <= WD4;
      RV1 <= RE1;
      RV2 <= RE2;
      if (RE1) RD1 <= rdata1;
      if (RE2) RD2 <= rdata2;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed steps followed by random traffic
// compared against an array-based reference model.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  a1, a2, a3, a4;
  logic        re1, re2, we3, we4;
  logic [31:0] wd3, wd4;
  logic [31:0] rd1, rd2;
  logic        rv1, rv2;

  logic [31:0] mmem [32];
  logic [31:0] erd1, erd2;
  logic        erv1, erv2;
  int          passes = 0;
  int          total  = 0;
  logic [31:0] exp30;

  always #5 clk = ~clk;

  reg_file_mp #(.DW(32), .AW(5), .ZERO_R0(1)) dut (
    .clk(clk), .rst(rst),
    .A1(a1), .A2(a2), .RE1(re1), .RE2(re2),
    .RD1(rd1), .RD2(rd2), .RV1(rv1), .RV2(rv2),
    .A3(a3), .WD3(wd3), .WE3(we3),
    .A4(a4), .WD4(wd4), .WE4(we4)
  );

  function automatic logic [31:0] mread(input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0) return 32'd0;
    v = mmem[a];
`ifdef REG_FILE_MP_BYPASS_EN
    if (we4 && a4 == a) v = wd4;
    else if (we3 && a3 == a) v = wd3;
`endif
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic idle();
    rst = 1'b0; re1 = 1'b0; re2 = 1'b0; we3 = 1'b0; we4 = 1'b0;
  endtask

  // Advance one clock, update the reference model from the inputs held across the edge, compare.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 32; i++) mmem[i] = 32'd0;
      erd1 = 32'd0; erd2 = 32'd0; erv1 = 1'b0; erv2 = 1'b0;
    end else begin
      erv1 = re1;
      erv2 = re2;
      if (re1) erd1 = mread(a1);
      if (re2) erd2 = mread(a2);
      if (we3 && a3 != 5'd0) mmem[a3] = wd3;
      if (we4 && a4 != 5'd0) mmem[a4] = wd4;
    end
    check("model_rd1", rd1, erd1);
    check("model_rd2", rd2, erd2);
    check("model_rv1", {31'd0, rv1}, {31'd0, erv1});
    check("model_rv2", {31'd0, rv2}, {31'd0, erv2});
  endtask

  initial begin
    a1 = '0; a2 = '0; a3 = '0; a4 = '0; wd3 = '0; wd4 = '0;
    idle();
    rst = 1'b1;
    cycle();
    check("reset_rd1", rd1, 32'd0);
    check("reset_rv1", {31'd0, rv1}, 32'd0);

    idle(); re1 = 1'b1; a1 = 5'd7;
    cycle();
    check("read7_rd1", rd1, 32'd0);
    check("read7_rv1", {31'd0, rv1}, 32'd1);

    idle();
    cycle();
    check("idle_rv1", {31'd0, rv1}, 32'd0);

    idle(); we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEADBEEF;
    cycle();
    idle(); re2 = 1'b1; a2 = 5'd5;
    cycle();
    check("wr5_rd2", rd2, 32'hDEADBEEF);
    check("wr5_rv2", {31'd0, rv2}, 32'd1);
    idle(); a2 = 5'd0;
    cycle();
    check("hold_rd2", rd2, 32'hDEADBEEF);
    check("hold_rv2", {31'd0, rv2}, 32'd0);

    idle(); re1 = 1'b1; re2 = 1'b1; a1 = 5'd5; a2 = 5'd5;
    cycle();
    check("same_addr_rd1", rd1, 32'hDEADBEEF);
    check("same_addr_rd2", rd2, 32'hDEADBEEF);

    idle(); we3 = 1'b1; a3 = 5'd9; wd3 = 32'h11; we4 = 1'b1; a4 = 5'd9; wd4 = 32'h22;
    cycle();
    idle(); re1 = 1'b1; a1 = 5'd9;
    cycle();
    check("portb_wins", rd1, 32'h22);

    idle(); we3 = 1'b1; a3 = 5'd12; wd3 = 32'hA;
    cycle();
    idle(); we3 = 1'b1; a3 = 5'd12; wd3 = 32'hB; re1 = 1'b1; a1 = 5'd12;
    cycle();
`ifdef REG_FILE_MP_BYPASS_EN
    exp30 = 32'hB;
`else
    exp30 = 32'hA;
`endif
    check("same_edge_rd1", rd1, exp30);
    idle(); re1 = 1'b1; a1 = 5'd12;
    cycle();
    check("after_write_rd1", rd1, 32'hB);

    idle(); we4 = 1'b1; a4 = 5'd0; wd4 = 32'hFFFFFFFF; re1 = 1'b1; a1 = 5'd0;
    cycle();
    check("r0_bypass_rd1", rd1, 32'd0);
    idle(); re1 = 1'b1; a1 = 5'd0;
    cycle();
    check("r0_read_rd1", rd1, 32'd0);

    idle(); we3 = 1'b1; a3 = 5'd3; wd3 = 32'h55;
    cycle();
    idle(); rst = 1'b1; re1 = 1'b1; a1 = 5'd3; we4 = 1'b1; a4 = 5'd4; wd4 = 32'h77;
    cycle();
    check("rst_read_rd1", rd1, 32'd0);
    check("rst_read_rv1", {31'd0, rv1}, 32'd0);
    idle(); re1 = 1'b1; a1 = 5'd3; re2 = 1'b1; a2 = 5'd4;
    cycle();
    check("post_rst_rd1", rd1, 32'd0);
    check("post_rst_rd2", rd2, 32'd0);
    check("post_rst_rv1", {31'd0, rv1}, 32'd1);

    for (int n = 0; n < 400; n++) begin
      logic narrow;
      narrow = ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 49) == 0);
      re1 = $urandom_range(0, 1); re2 = $urandom_range(0, 1);
      we3 = $urandom_range(0, 1); we4 = $urandom_range(0, 1);
      a1 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      a2 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      a3 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      a4 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wd3 = $urandom; wd4 = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
